// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes,
// the frame FSM state encoding and a frame-length helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // Total clock cycles for one frame: start + data + optional parity + stop bits.
  function automatic int frame_cycles(input int cpb, input int dbits,
                                      input int pmode, input int sbits);
    return (1 + dbits + ((pmode != PARITY_NONE) ? 1 : 0) + sbits) * cpb;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; push while full and
// pop while empty are ignored. Pointers wrap naturally (DEPTH is a power of 2).
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter fed by a small FIFO. Defining UART_TX_BREAK_EN
// adds a brk input that holds the line low between frames.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                        brk,
`endif
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int BAUD_W = $clog2(frame_cycles(CLKS_PER_BIT, DATA_BITS, PARITY_MODE, STOP_BITS));
  localparam logic [BIT_W-1:0]  BIT_LAST       = BIT_W'(DATA_BITS - 1);
  localparam logic [BAUD_W-1:0] BAUD_BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_STOP_LAST = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);

  uart_state_t          state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 load;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;
`ifdef UART_TX_BREAK_EN
  logic                 hold_q, hold_d;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx       = tx_q;
  assign tx_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || !fifo_empty;

  // Next-state logic; "load" pops the FIFO head and starts a frame on this edge.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BAUD_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
`ifdef UART_TX_BREAK_EN
    hold_d   = hold_q;
`endif

    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
`ifdef UART_TX_BREAK_EN
        // After a break the line must sit high for a full bit before any START.
        if (brk) begin
          tx_d   = 1'b0;
          hold_d = 1'b1;
        end else if (hold_q) begin
          if (!tx_q) begin
            baud_d = '0;
          end else if (baud_q == BAUD_BIT_LAST) begin
            hold_d = 1'b0;
            load   = !fifo_empty;
          end else begin
            baud_d = baud_q + BAUD_W'(1);
          end
        end else begin
          load = !fifo_empty;
        end
`else
        load = !fifo_empty;
`endif
      end

      START: begin
        if (baud_q == BAUD_BIT_LAST) begin
          baud_d  = '0;
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end

      DATA: begin
        if (baud_q == BAUD_BIT_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            if (HAS_PARITY) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end

      PARITY: begin
        if (baud_q == BAUD_BIT_LAST) begin
          baud_d  = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        if (baud_q == BAUD_STOP_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
`ifdef UART_TX_BREAK_EN
          load    = !fifo_empty && !brk;
`else
          load    = !fifo_empty;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      state_d  = START;
      tx_d     = 1'b0;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = fifo_head;
      par_d    = (PARITY_MODE == PARITY_ODD) ? ~(^fifo_head) : (^fifo_head);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_TX_BREAK_EN
      hold_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
`ifdef UART_TX_BREAK_EN
      hold_q  <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: four instances (8N1, 8E1, 8O1, 7N2) at
// CLKS_PER_BIT=4, a serial-line monitor and a frame scoreboard.
module tb_uart_tx_fifo_param;

  localparam int CPB = 4;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
  } frame_t;

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [15:0] bits;
    int          nbits;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [1:0] sel = 2'd0;
`ifdef UART_TX_BREAK_EN
  logic       brk = 1'b0;
`endif

  logic [3:0] v;
  logic [3:0] tx_w, busy_w, rdy_w;
  logic [2:0] cnt_w [4];
  logic       tx_m, busy_m, rdy_m;
  logic [2:0] cnt_m;

  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;
  bit     mon_en = 1'b0;
  bit     mon_busy = 1'b0;
  frame_t sb[$];
  int     starts[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v      = tx_valid ? (4'b0001 << sel) : 4'b0000;
  assign tx_m   = tx_w[sel];
  assign busy_m = busy_w[sel];
  assign rdy_m  = rdy_w[sel];
  assign cnt_m  = cnt_w[sel];

  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v[0]),
`ifdef UART_TX_BREAK_EN
    .brk(brk),
`endif
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));

  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v[1]),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));

  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v[2]),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));

  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[6:0]), .tx_valid(v[3]),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]));

  // Serial frame as seen on the line, bit k = k-th bit period (start first).
  function automatic logic [15:0] model_frame(input logic [7:0] d, input int db,
                                              input int pm, input int sbn);
    logic [15:0] f;
    int          pos;
    logic        p;
    f   = '0;
    pos = 1;
    p   = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[pos] = d[i];
      p      = p ^ d[i];
      pos++;
    end
    if (pm != 0) begin
      f[pos] = (pm == 2) ? ~p : p;
      pos++;
    end
    for (int i = 0; i < sbn; i++) begin
      f[pos] = 1'b1;
      pos++;
    end
    return f;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] s, input logic [7:0] d, output int c_pre);
    sel = s;
    @(negedge clk);
    c_pre    = cyc;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drained", sb.size() + int'(mon_busy), 0);
  endtask

  // Line monitor: decodes each frame at bit centres and compares with the scoreboard.
  initial begin : monitor
    frame_t      e;
    logic [15:0] got;
    bit          have;
    forever begin
      @(negedge clk);
      if (mon_en && tx_m === 1'b0) begin
        mon_busy = 1'b1;
        starts.push_back(cyc);
        have = (sb.size() != 0);
        if (have) e = sb.pop_front();
        else begin
          e.bits  = '0;
          e.nbits = 10;
        end
        got = '0;
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < e.nbits; k++) begin
          got[k] = tx_m;
          if (k != e.nbits - 1) repeat (CPB) @(negedge clk);
        end
        repeat (CPB - 1 - CPB / 2) @(negedge clk);
        checkOutput("frame_expected", int'(have), 1);
        checkOutput("frame_bits", int'(got), int'(e.bits));
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vec_t   vecs[9];
    frame_t f;
    int     c_pre, t0, n, low, hi;
    int     acc[7];

    vecs[0] = '{2'd0, 8'hA5, 16'h034A, 10};
    vecs[1] = '{2'd0, 8'h00, 16'h0200, 10};
    vecs[2] = '{2'd0, 8'hFF, 16'h03FE, 10};
    vecs[3] = '{2'd1, 8'h07, 16'h060E, 11};
    vecs[4] = '{2'd2, 8'h07, 16'h040E, 11};
    vecs[5] = '{2'd1, 8'h03, 16'h0406, 11};
    vecs[6] = '{2'd2, 8'h00, 16'h0600, 11};
    vecs[7] = '{2'd3, 8'h7F, 16'h03FE, 10};
    vecs[8] = '{2'd3, 8'h2A, 16'h0354, 10};

    #1 rst = 1'b1;
    #1;
    checkOutput("reset_tx", int'(tx_m), 1);
    checkOutput("reset_busy", int'(busy_m), 0);
    checkOutput("reset_count", int'(cnt_m), 0);
    checkOutput("reset_ready", int'(rdy_m), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    $display("[TB] single-frame vectors");
    for (int i = 0; i < 9; i++) begin
      f.bits  = vecs[i].bits;
      f.nbits = vecs[i].nbits;
      sb.push_back(f);
      applyStimulus(vecs[i].sel, vecs[i].data, c_pre);
      n = 0;
      @(negedge clk);
      while (tx_m !== 1'b0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      t0 = cyc;
      checkOutput("start_latency", t0 - c_pre - 1, 1);
      n = 0;
      while (busy_m && n < 500) begin
        @(negedge clk);
        n++;
      end
      checkOutput("busy_cycles", cyc - t0, vecs[i].nbits * CPB);
      waitDrain(200);
      repeat (3) @(negedge clk);
    end

    $display("[TB] six-word burst into depth-4 FIFO");
    sel = 2'd0;
    starts.delete();
    @(negedge clk);
    for (int w = 1; w <= 6; w++) begin
      f.bits  = model_frame(8'(w), 8, 0, 1);
      f.nbits = 10;
      sb.push_back(f);
      tx_data  = 8'(w);
      tx_valid = 1'b1;
      n = 0;
      while (!rdy_m && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      @(posedge clk);
      #1;
      acc[w] = cyc;
      if (w == 5) begin
        checkOutput("ready_when_full", int'(rdy_m), 0);
        checkOutput("count_when_full", int'(cnt_m), 4);
      end
    end
    tx_valid = 1'b0;
    checkOutput("five_consecutive_accepts", acc[5] - acc[1], 4);
    checkOutput("sixth_accept_at_boundary", acc[6] - acc[1], 42);
    waitDrain(600);
    checkOutput("burst_frame_count", starts.size(), 6);
    for (int k = 1; k < starts.size(); k++)
      checkOutput("back_to_back_gap", starts[k] - starts[k-1], 40);
    repeat (3) @(negedge clk);

    $display("[TB] reset mid-frame");
    mon_en = 1'b0;
    sel = 2'd0;
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data  = 8'h22;
    @(posedge clk); #1;
    tx_data  = 8'h33;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("count_before_reset", int'(cnt_m), 2);
    checkOutput("tx_low_in_data", int'(tx_m), 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midframe_reset_tx", int'(tx_m), 1);
    checkOutput("midframe_reset_count", int'(cnt_m), 0);
    checkOutput("midframe_reset_ready", int'(rdy_m), 1);
    checkOutput("midframe_reset_busy", int'(busy_m), 0);
    @(negedge clk);
    rst = 1'b0;
    low = 0;
    repeat (300) begin
      @(negedge clk);
      if (!tx_m) low++;
    end
    checkOutput("no_frames_after_reset", low, 0);

`ifdef UART_TX_BREAK_EN
    $display("[TB] line break");
    sel = 2'd0;
    mon_en = 1'b1;
    f.bits  = model_frame(8'h5A, 8, 0, 1);
    f.nbits = 10;
    sb.push_back(f);
    @(negedge clk);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data  = 8'h3C;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    brk = 1'b1;
    waitDrain(200);
    mon_en = 1'b0;
    n = 0;
    while (tx_m !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("break_line_low", int'(tx_m), 0);
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_m) hi++;
    end
    checkOutput("break_held_low", hi, 0);
    checkOutput("break_no_pop", int'(cnt_m), 1);
    f.bits  = model_frame(8'h3C, 8, 0, 1);
    f.nbits = 10;
    sb.push_back(f);
    brk = 1'b0;
    mon_en = 1'b1;
    hi = 0;
    n = 0;
    @(negedge clk);
    while (tx_m && n < 100) begin
      hi++;
      @(negedge clk);
      n++;
    end
    checkOutput("idle_bit_after_break", int'(hi >= CPB), 1);
    waitDrain(200);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
